// File: rtl/conv2d_stream_pkg.sv
// Shared types and helpers for the conv2d_stream engine.
//   state_e   : control FSM states
//   out_dim   : output height/width from input size and window geometry
//   saturate  : clamp a wide signed value to a dw-bit signed range
//   flat_idx4 : row-major flat index of a 4-D coordinate
package conv2d_stream_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StEmit, StDone} state_e;

  // Working width of the saturation helper; must cover ACC_WIDTH.
  localparam int unsigned SatW = 128;

  function automatic int out_dim(input int in_size, input int k, input int s, input int p,
                                 input int d);
    return (in_size + 2 * p - d * (k - 1) - 1) / s + 1;
  endfunction

  function automatic logic signed [SatW-1:0] saturate(input logic signed [SatW-1:0] v,
                                                      input int dw);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = $signed((SatW'(1) << (dw - 1)) - SatW'(1));
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int flat_idx4(input int a, input int b, input int c, input int d,
                                   input int nb, input int nc, input int nd);
    return ((a * nb + b) * nc + c) * nd + d;
  endfunction

endpackage

// File: rtl/conv2d_stream_mac.sv
// Signed multiply-accumulate with registered accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   load     : acc <= (bias <<< FRAC_BITS) + a*b  (first tap of a window)
//   en       : acc <= acc + a*b
//   a, b     : signed operands (activation, weight)
//   bias     : signed bias in Q(FRAC_BITS)
//   acc      : accumulator value
module conv2d_stream_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 8,
  parameter int FRAC_BITS  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic signed [ACC_WIDTH-1:0]    acc_q;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      // Bias is aligned to the product's 2*FRAC_BITS scale.
      acc_d = (ACC_WIDTH'(bias) <<< FRAC_BITS) + ACC_WIDTH'(prod);
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv2d_stream.sv
// Sequential 2-D convolution engine, one MAC per cycle, valid/ready output stream.
//   clk, rst           : clock, asynchronous active-high reset
//   start, busy, done  : launch (sampled in idle), run indicator, one-cycle completion pulse
//   input_tensor_flat  : activations, order b,c,h,w
//   weights_flat       : weights, order oc,ic,kh,kw
//   bias_flat          : one bias per output channel
//   out_valid/out_ready: output handshake; out_data/out_idx held while stalled
//   output_tensor_flat : each element written on its handshake
// Optional macro CONV2D_STREAM_RELU_EN: clamp negative results to zero before emit/store.
module conv2d_stream
  import conv2d_stream_pkg::*;
#(
  parameter int  BATCH_SIZE   = 1,
  parameter int  IN_CHANNELS  = 2,
  parameter int  OUT_CHANNELS = 1,
  parameter int  IN_HEIGHT    = 4,
  parameter int  IN_WIDTH     = 4,
  parameter int  KERNEL_SIZE  = 2,
  parameter int  STRIDE       = 2,
  parameter int  PADDING      = 0,
  parameter int  DILATION     = 1,
  parameter int  DATA_WIDTH   = 32,
  parameter int  FRAC_BITS    = 0,
  parameter int  ACC_WIDTH    = 2 * DATA_WIDTH + 8,
  localparam int OUT_H = out_dim(IN_HEIGHT, KERNEL_SIZE, STRIDE, PADDING, DILATION),
  localparam int OUT_W = out_dim(IN_WIDTH, KERNEL_SIZE, STRIDE, PADDING, DILATION),
  localparam int N_OUT = BATCH_SIZE * OUT_CHANNELS * OUT_H * OUT_W,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int IN_BITS = BATCH_SIZE * IN_CHANNELS * IN_HEIGHT * IN_WIDTH * DATA_WIDTH,
  localparam int W_BITS  = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  input  logic [IN_BITS-1:0]            input_tensor_flat,
  input  logic [W_BITS-1:0]             weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0] bias_flat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic [N_OUT*DATA_WIDTH-1:0]   output_tensor_flat,
  output logic                          done
);

  state_e state_q, state_d;

  logic [IN_BITS-1:0]                 in_q;
  logic [W_BITS-1:0]                  w_q;
  logic [OUT_CHANNELS*DATA_WIDTH-1:0] bias_q;
  logic [N_OUT*DATA_WIDTH-1:0]        out_tensor_q;
  logic [IDX_W-1:0]                   idx_q;
  int b_q, oc_q, oh_q, ow_q;
  int ic_q, kh_q, kw_q;

  int row, col, in_idx, w_idx;
  logic in_range, last_tap, last_out, first_tap;
  logic [DATA_WIDTH-1:0] tap_x, tap_w, tap_bias;
  logic signed [ACC_WIDTH-1:0] acc, acc_sh;
  logic [DATA_WIDTH-1:0] sat_v, res;

  assign last_tap  = (ic_q == IN_CHANNELS - 1) && (kh_q == KERNEL_SIZE - 1) &&
                     (kw_q == KERNEL_SIZE - 1);
  assign first_tap = (ic_q == 0) && (kh_q == 0) && (kw_q == 0);
  assign last_out  = (b_q == BATCH_SIZE - 1) && (oc_q == OUT_CHANNELS - 1) &&
                     (oh_q == OUT_H - 1) && (ow_q == OUT_W - 1);

  // Tap operand fetch; taps falling in the padding border contribute zero.
  always_comb begin
    row      = oh_q * STRIDE + kh_q * DILATION - PADDING;
    col      = ow_q * STRIDE + kw_q * DILATION - PADDING;
    in_range = (row >= 0) && (row < IN_HEIGHT) && (col >= 0) && (col < IN_WIDTH);
    in_idx   = 0;
    if (in_range) in_idx = flat_idx4(b_q, ic_q, row, col, IN_CHANNELS, IN_HEIGHT, IN_WIDTH);
    w_idx    = flat_idx4(oc_q, ic_q, kh_q, kw_q, IN_CHANNELS, KERNEL_SIZE, KERNEL_SIZE);
    tap_x    = in_range ? in_q[in_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    tap_w    = w_q[w_idx*DATA_WIDTH +: DATA_WIDTH];
    tap_bias = bias_q[oc_q*DATA_WIDTH +: DATA_WIDTH];
  end

  conv2d_stream_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .load(state_q == StMac && first_tap),
    .en  (state_q == StMac),
    .a   (tap_x),
    .b   (tap_w),
    .bias(tap_bias),
    .acc (acc)
  );

  always_comb begin
    acc_sh = acc >>> FRAC_BITS;
    sat_v  = DATA_WIDTH'(saturate(SatW'(acc_sh), DATA_WIDTH));
`ifdef CONV2D_STREAM_RELU_EN
    res    = sat_v[DATA_WIDTH-1] ? '0 : sat_v;
`else
    res    = sat_v;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StMac;
      StMac:   if (last_tap) state_d = StEmit;
      StEmit:  if (out_ready) state_d = last_out ? StDone : StMac;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      in_q         <= '0;
      w_q          <= '0;
      bias_q       <= '0;
      out_tensor_q <= '0;
      idx_q        <= '0;
      b_q  <= 0; oc_q <= 0; oh_q <= 0; ow_q <= 0;
      ic_q <= 0; kh_q <= 0; kw_q <= 0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StLoad: begin
          in_q   <= input_tensor_flat;
          w_q    <= weights_flat;
          bias_q <= bias_flat;
          idx_q  <= '0;
          b_q  <= 0; oc_q <= 0; oh_q <= 0; ow_q <= 0;
          ic_q <= 0; kh_q <= 0; kw_q <= 0;
        end
        StMac: begin
          // kw fastest; all three wrap to zero after the last tap.
          if (kw_q == KERNEL_SIZE - 1) begin
            kw_q <= 0;
            if (kh_q == KERNEL_SIZE - 1) begin
              kh_q <= 0;
              ic_q <= (ic_q == IN_CHANNELS - 1) ? 0 : ic_q + 1;
            end else begin
              kh_q <= kh_q + 1;
            end
          end else begin
            kw_q <= kw_q + 1;
          end
        end
        StEmit: begin
          if (out_ready) begin
            out_tensor_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= res;
            idx_q <= idx_q + 1'b1;
            if (ow_q == OUT_W - 1) begin
              ow_q <= 0;
              if (oh_q == OUT_H - 1) begin
                oh_q <= 0;
                if (oc_q == OUT_CHANNELS - 1) begin
                  oc_q <= 0;
                  b_q  <= (b_q == BATCH_SIZE - 1) ? 0 : b_q + 1;
                end else begin
                  oc_q <= oc_q + 1;
                end
              end else begin
                oh_q <= oh_q + 1;
              end
            end else begin
              ow_q <= ow_q + 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy               = (state_q == StLoad) || (state_q == StMac) || (state_q == StEmit);
  assign done               = (state_q == StDone);
  assign out_valid          = (state_q == StEmit);
  assign out_data           = out_valid ? res : '0;
  assign out_idx            = out_valid ? idx_q : '0;
  assign output_tensor_flat = out_tensor_q;

endmodule
